// File: rtl/memory_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (fetch and data) and the shared memory.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface memory_arbiter_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic             if_ack;
  logic [DataW-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_wdata;
  logic             d_ack;
  logic [DataW-1:0] d_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data accesses,
// with a wait-state timeout that completes the access with err instead of hanging.
module memory_arbiter (
  input  logic                    clk,
  input  logic                    reset,
  memory_arbiter_if.master        bus,
  output logic                    busy,
  output logic                    err
);
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;
  // Count seen in the 15th ready-less BUSY cycle; one more miss reaches 15 and times out.
  localparam logic [CntW-1:0] LastWait = CntW'(14);
  localparam logic GrantFetch = 1'b0;
  localparam logic GrantData  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  waitCnt, waitCntNext;
  logic             lastGrant, lastGrantNext;
  logic             memEn, memEnNext;
  logic             memWe, memWeNext;
  logic [AddrW-1:0] memAddr, memAddrNext;
  logic [DataW-1:0] memWdata, memWdataNext;
  logic             ifAck, ifAckNext;
  logic             dAck, dAckNext;
  logic [DataW-1:0] ifRdata, ifRdataNext;
  logic [DataW-1:0] dRdata, dRdataNext;
  logic             busyNext, errNext;
  logic             fetchWins;

  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_ack    = ifAck;
  assign bus.d_ack     = dAck;
  assign bus.if_rdata  = ifRdata;
  assign bus.d_rdata   = dRdata;

  // Next-state, grant, completion and output-register decode.
  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    lastGrantNext = lastGrant;
    memEnNext     = 1'b0;
    memWeNext     = memWe;
    memAddrNext   = memAddr;
    memWdataNext  = memWdata;
    ifAckNext     = 1'b0;
    dAckNext      = 1'b0;
    ifRdataNext   = ifRdata;
    dRdataNext    = dRdata;
    errNext       = 1'b0;
    // Fetch takes a tie only when data was granted last.
    fetchWins     = bus.if_req && (!bus.d_req || lastGrant == GrantData);

    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          stateNext   = BUSY;
          waitCntNext = '0;
          memEnNext   = 1'b1;
          if (fetchWins) begin
            lastGrantNext = GrantFetch;
            memWeNext     = 1'b0;
            memAddrNext   = bus.if_addr;
            memWdataNext  = '0;
          end else begin
            lastGrantNext = GrantData;
            memWeNext     = bus.d_we;
            memAddrNext   = bus.d_addr;
            memWdataNext  = bus.d_wdata;
          end
        end
      end

      BUSY: begin
        memEnNext = 1'b1;
        if (bus.mem_ready || waitCnt == LastWait) begin
          stateNext = RESP;
          memEnNext = 1'b0;
          memWeNext = 1'b0;
          ifAckNext = (lastGrant == GrantFetch);
          dAckNext  = (lastGrant == GrantData);
          if (!bus.mem_ready) begin
            waitCntNext = waitCnt + CntW'(1);
            errNext     = 1'b1;
          end else if (lastGrant == GrantFetch) begin
            ifRdataNext = bus.mem_rdata;
          end else if (!memWe) begin
            dRdataNext = bus.mem_rdata;
          end
        end else begin
          waitCntNext = waitCnt + CntW'(1);
        end
      end

      RESP: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      lastGrant <= GrantData;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      ifAck     <= 1'b0;
      dAck      <= 1'b0;
      ifRdata   <= '0;
      dRdata    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      lastGrant <= lastGrantNext;
      memEn     <= memEnNext;
      memWe     <= memWeNext;
      memAddr   <= memAddrNext;
      memWdata  <= memWdataNext;
      ifAck     <= ifAckNext;
      dAck      <= dAckNext;
      ifRdata   <= ifRdataNext;
      dRdata    <= dRdataNext;
      busy      <= busyNext;
      err       <= errNext;
    end
  end
endmodule
